// File: rtl/ysyx_040750_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_040750_mem_arbiter_pkg
// Shared types and constants for the core memory-port arbiter.
//   - arb_state_e : arbiter FSM state encoding
//   - *_DEF       : default widths / streak limit used as module parameter defaults
//   - STREAK_W    : width of the LSU streak counter (holds up to 15)
// ----------------------------------------------------------------------------
package ysyx_040750_mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF        = 32;
   localparam int unsigned DATA_W_DEF        = 64;
   localparam int unsigned MAX_LS_STREAK_DEF = 4;
   localparam int unsigned STREAK_W          = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_REQ  = 3'd1,
      IF_WAIT = 3'd2,
      LS_REQ  = 3'd3,
      LS_WAIT = 3'd4
   } arb_state_e;

endpackage

// File: rtl/ysyx_040750_arb_prio.sv
// ----------------------------------------------------------------------------
// ysyx_040750_arb_prio
// Grant selection between fetch and LSU plus the anti-starvation streak count.
// Ports:
//   I_sys_clk, I_rst      : clock, synchronous active-high reset
//   i_arb_en              : arbitration slot (arbiter idle, not in reset)
//   i_if_valid/i_ls_valid : pending requests
//   o_grant_if/o_grant_ls : one-hot grant, only while i_arb_en
// ----------------------------------------------------------------------------
module ysyx_040750_arb_prio
   import ysyx_040750_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
   input  logic I_sys_clk,
   input  logic I_rst,
   input  logic i_arb_en,
   input  logic i_if_valid,
   input  logic i_ls_valid,
   output logic o_grant_if,
   output logic o_grant_ls
);

   localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_LS_STREAK);

   logic [STREAK_W-1:0] r_streak;
   logic [STREAK_W-1:0] w_streak_d;

   always_comb begin
      // LSU wins unless fetch is waiting and LSU has used up its streak.
      o_grant_ls = i_arb_en && i_ls_valid && (!i_if_valid || (r_streak < MaxStreak));
      o_grant_if = i_arb_en && i_if_valid && !o_grant_ls;
      w_streak_d = r_streak;
      if (o_grant_ls) begin
         // Only grants that actually made fetch wait count towards the streak.
         if (!i_if_valid) begin
            w_streak_d = '0;
         end else if (r_streak != '1) begin
            w_streak_d = r_streak + STREAK_W'(1);
         end
      end else if (o_grant_if) begin
         w_streak_d = '0;
      end
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         r_streak <= '0;
      end else begin
         r_streak <= w_streak_d;
      end
   end

endmodule

// File: rtl/ysyx_040750_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_040750_mem_arbiter
// Shares the single core memory port between instruction fetch (IF) and the
// load/store unit (LS). One transaction outstanding at a time.
// Ports:
//   I_sys_clk, I_rst            : clock, synchronous active-high reset
//   I_if_* / O_if_*             : fetch request (valid/ready) and response pulse
//   I_if_flush                  : drop the in-flight fetch response
//   I_ls_* / O_ls_*             : LSU request (valid/ready) and response pulse
//   O_mem_* / I_mem_*           : memory request (valid/ready) and response
// ----------------------------------------------------------------------------
module ysyx_040750_mem_arbiter
   import ysyx_040750_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W        = ADDR_W_DEF,
   parameter int unsigned DATA_W        = DATA_W_DEF,
   parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
   input  logic                  I_sys_clk,
   input  logic                  I_rst,
   input  logic                  I_if_req_valid,
   input  logic [ADDR_W-1:0]     I_if_addr,
   output logic                  O_if_req_ready,
   output logic                  O_if_resp_valid,
   output logic [DATA_W-1:0]     O_if_rdata,
   input  logic                  I_if_flush,
   input  logic                  I_ls_req_valid,
   input  logic                  I_ls_wen,
   input  logic [ADDR_W-1:0]     I_ls_addr,
   input  logic [DATA_W-1:0]     I_ls_wdata,
   input  logic [DATA_W/8-1:0]   I_ls_wmask,
   output logic                  O_ls_req_ready,
   output logic                  O_ls_resp_valid,
   output logic [DATA_W-1:0]     O_ls_rdata,
   output logic                  O_mem_req_valid,
   output logic                  O_mem_wen,
   output logic [ADDR_W-1:0]     O_mem_addr,
   output logic [DATA_W-1:0]     O_mem_wdata,
   output logic [DATA_W/8-1:0]   O_mem_wmask,
   input  logic                  I_mem_req_ready,
   input  logic                  I_mem_resp_valid,
   input  logic [DATA_W-1:0]     I_mem_rdata
);

   arb_state_e r_state;
   arb_state_e w_state_d;
   logic       r_drop;
   logic       w_drop_d;
   logic       w_arb_en;
   logic       w_grant_if;
   logic       w_grant_ls;
   logic       w_if_deliver;

   assign w_arb_en = (r_state == IDLE) && !I_rst;

   ysyx_040750_arb_prio #(
      .MAX_LS_STREAK (MAX_LS_STREAK)
   ) u_arb_prio (
      .I_sys_clk  (I_sys_clk),
      .I_rst      (I_rst),
      .i_arb_en   (w_arb_en),
      .i_if_valid (I_if_req_valid),
      .i_ls_valid (I_ls_req_valid),
      .o_grant_if (w_grant_if),
      .o_grant_ls (w_grant_ls)
   );

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         r_state <= IDLE;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_drop  <= w_drop_d;
      end
   end

   always_comb begin
      w_state_d       = r_state;
      w_drop_d        = r_drop;
      w_if_deliver    = 1'b0;
      O_if_req_ready  = 1'b0;
      O_if_resp_valid = 1'b0;
      O_if_rdata      = '0;
      O_ls_req_ready  = 1'b0;
      O_ls_resp_valid = 1'b0;
      O_ls_rdata      = '0;
      O_mem_req_valid = 1'b0;
      O_mem_wen       = 1'b0;
      O_mem_addr      = '0;
      O_mem_wdata     = '0;
      O_mem_wmask     = '0;
      // Outputs are held quiet during reset so a mid-transaction reset never
      // leaks a response pulse.
      if (!I_rst) begin
         unique case (r_state)
            IDLE: begin
               w_drop_d = 1'b0;
               if (w_grant_ls) begin
                  w_state_d = LS_REQ;
               end else if (w_grant_if) begin
                  w_state_d = IF_REQ;
               end
            end
            IF_REQ: begin
               O_mem_req_valid = 1'b1;
               O_mem_addr      = I_if_addr;
               O_if_req_ready  = I_mem_req_ready;
               if (I_if_flush) begin
                  w_drop_d = 1'b1;
               end
               if (I_mem_req_ready) begin
                  w_state_d = IF_WAIT;
               end
            end
            IF_WAIT: begin
               if (I_if_flush) begin
                  w_drop_d = 1'b1;
               end
               if (I_mem_resp_valid) begin
                  // A flush in the response cycle itself also kills the pulse.
                  w_if_deliver    = !(r_drop || I_if_flush);
                  O_if_resp_valid = w_if_deliver;
                  O_if_rdata      = w_if_deliver ? I_mem_rdata : '0;
                  w_state_d       = IDLE;
                  w_drop_d        = 1'b0;
               end
            end
            LS_REQ: begin
               O_mem_req_valid = 1'b1;
               O_mem_wen       = I_ls_wen;
               O_mem_addr      = I_ls_addr;
               O_mem_wdata     = I_ls_wdata;
               O_mem_wmask     = I_ls_wmask;
               O_ls_req_ready  = I_mem_req_ready;
               if (I_mem_req_ready) begin
                  w_state_d = LS_WAIT;
               end
            end
            LS_WAIT: begin
               if (I_mem_resp_valid) begin
                  O_ls_resp_valid = 1'b1;
                  O_ls_rdata      = I_mem_rdata;
                  w_state_d       = IDLE;
               end
            end
            default: begin
               w_state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_040750_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_040750_mem_arbiter
// Bench for the memory-port arbiter: requester queues, a latency-randomised
// memory, and a transaction-level reference (grant order, streak, data, drop).
// ----------------------------------------------------------------------------
module tb_ysyx_040750_mem_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 64;
   localparam int unsigned MW   = DW / 8;
   localparam int unsigned MAXS = 4;

   typedef struct packed {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wmask;
   } ls_req_t;

   logic          I_sys_clk = 1'b0;
   logic          I_rst;
   logic          I_if_req_valid;
   logic [AW-1:0] I_if_addr;
   logic          O_if_req_ready;
   logic          O_if_resp_valid;
   logic [DW-1:0] O_if_rdata;
   logic          I_if_flush;
   logic          I_ls_req_valid;
   logic          I_ls_wen;
   logic [AW-1:0] I_ls_addr;
   logic [DW-1:0] I_ls_wdata;
   logic [MW-1:0] I_ls_wmask;
   logic          O_ls_req_ready;
   logic          O_ls_resp_valid;
   logic [DW-1:0] O_ls_rdata;
   logic          O_mem_req_valid;
   logic          O_mem_wen;
   logic [AW-1:0] O_mem_addr;
   logic [DW-1:0] O_mem_wdata;
   logic [MW-1:0] O_mem_wmask;
   logic          I_mem_req_ready;
   logic          I_mem_resp_valid;
   logic [DW-1:0] I_mem_rdata;

   always #5 I_sys_clk = ~I_sys_clk;

   ysyx_040750_mem_arbiter #(
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .MAX_LS_STREAK (MAXS)
   ) dut (
      .I_sys_clk        (I_sys_clk),
      .I_rst            (I_rst),
      .I_if_req_valid   (I_if_req_valid),
      .I_if_addr        (I_if_addr),
      .O_if_req_ready   (O_if_req_ready),
      .O_if_resp_valid  (O_if_resp_valid),
      .O_if_rdata       (O_if_rdata),
      .I_if_flush       (I_if_flush),
      .I_ls_req_valid   (I_ls_req_valid),
      .I_ls_wen         (I_ls_wen),
      .I_ls_addr        (I_ls_addr),
      .I_ls_wdata       (I_ls_wdata),
      .I_ls_wmask       (I_ls_wmask),
      .O_ls_req_ready   (O_ls_req_ready),
      .O_ls_resp_valid  (O_ls_resp_valid),
      .O_ls_rdata       (O_ls_rdata),
      .O_mem_req_valid  (O_mem_req_valid),
      .O_mem_wen        (O_mem_wen),
      .O_mem_addr       (O_mem_addr),
      .O_mem_wdata      (O_mem_wdata),
      .O_mem_wmask      (O_mem_wmask),
      .I_mem_req_ready  (I_mem_req_ready),
      .I_mem_resp_valid (I_mem_resp_valid),
      .I_mem_rdata      (I_mem_rdata)
   );

   // Requester queues (head is what is presented), memory image, reference image.
   logic [AW-1:0] if_q[$];
   ls_req_t       ls_q[$];
   logic [DW-1:0] mem_arr[logic [AW-1:0]];
   logic [DW-1:0] ref_arr[logic [AW-1:0]];

   int n_checks = 0;
   int n_pass   = 0;

   // Stimulus knobs.
   int          cyc, flush_cyc, rst_cyc;
   bit          rst_force;
   int          rdy_mode;          // 0 / 1 fixed, 2 random
   int unsigned lat_min, lat_max, flush_pct;

   // Memory agent.
   bit            m_pend;
   int            m_cnt;
   logic [DW-1:0] m_data;

   // Reference model of the transaction in flight.
   int            streak;
   bit            own_act, own_ls, own_acc, own_drop, own_wen;
   logic [DW-1:0] own_data;
   bit            prev_ifv, prev_lsv, prev_mrv, prev_mrdy, prev_wen;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_wdata;
   logic [MW-1:0] prev_wmask;

   // Per-phase observations.
   string         glog;
   int            n_if_resp, n_ls_resp, n_mrv, acc_cyc, resp_cyc;
   logic [DW-1:0] last_if_data;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {a ^ 32'h5a5a_5a5a, a};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < int'(MW); i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
      return ref_arr.exists(a) ? ref_arr[a] : dflt(a);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic begin_phase();
      cyc          = 0;
      glog         = "";
      n_if_resp    = 0;
      n_ls_resp    = 0;
      n_mrv        = 0;
      acc_cyc      = -1;
      resp_cyc     = -1;
      last_if_data = '0;
   endtask

   // One clock: drive inputs, check at negedge, advance the models.
   task automatic tick();
      bit      exp_ls, exp_if, act_ls, e_ifrdy, e_lsrdy, e_ifrv, e_lsrv;
      ls_req_t head;
      I_rst            = rst_force || (cyc == rst_cyc);
      I_if_req_valid   = (if_q.size() > 0);
      I_if_addr        = (if_q.size() > 0) ? if_q[0] : '0;
      head             = (ls_q.size() > 0) ? ls_q[0] : '0;
      I_ls_req_valid   = (ls_q.size() > 0);
      I_ls_wen         = head.wen;
      I_ls_addr        = head.addr;
      I_ls_wdata       = head.wdata;
      I_ls_wmask       = head.wmask;
      I_if_flush       = (cyc == flush_cyc) || ($urandom_range(99) < flush_pct);
      I_mem_req_ready  = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode != 0);
      I_mem_resp_valid = m_pend && (m_cnt == 0);
      I_mem_rdata      = I_mem_resp_valid ? m_data : {$urandom, $urandom};
      @(negedge I_sys_clk);
      if (I_rst) begin
         chk("rst_ctl", {O_if_req_ready, O_if_resp_valid, O_ls_req_ready, O_ls_resp_valid,
                         O_mem_req_valid, O_mem_wen}, '0);
         chk("rst_addr", O_mem_addr, '0);
         chk("rst_data", O_if_rdata | O_ls_rdata | O_mem_wdata, '0);
         chk("rst_wmask", O_mem_wmask, '0);
         m_pend   = 0;
         own_act  = 0;
         own_acc  = 0;
         streak   = 0;
         prev_ifv = 0; prev_lsv = 0; prev_mrv = 0; prev_mrdy = 0;
      end else begin
         // A new request appears one cycle after the arbitration slot.
         if (O_mem_req_valid && !prev_mrv) begin
            exp_ls = prev_lsv && (!prev_ifv || streak < int'(MAXS));
            exp_if = prev_ifv && !exp_ls;
            act_ls = (O_mem_addr[31:28] == 4'h8);
            glog   = {glog, act_ls ? "L" : "I"};
            chk("grant_any", exp_ls || exp_if, 1);
            chk("grant_ls", act_ls, exp_ls);
            if (exp_ls) streak = prev_ifv ? ((streak < 15) ? streak + 1 : 15) : 0;
            else        streak = 0;
            own_act = 1; own_ls = exp_ls; own_acc = 0; own_drop = 0;
         end
         if (O_mem_req_valid) begin
            n_mrv++;
            chk("req_owner", own_act && !own_acc, 1);
            if (own_act && own_ls) begin
               chk("ls_head", ls_q.size() > 0, 1);
               if (ls_q.size() > 0) begin
                  chk("mem_addr_ls", O_mem_addr, ls_q[0].addr);
                  chk("mem_wen_ls", O_mem_wen, ls_q[0].wen);
                  chk("mem_wdata_ls", O_mem_wdata, ls_q[0].wdata);
                  chk("mem_wmask_ls", O_mem_wmask, ls_q[0].wmask);
               end
            end else if (own_act) begin
               chk("if_head", if_q.size() > 0, 1);
               if (if_q.size() > 0) chk("mem_addr_if", O_mem_addr, if_q[0]);
               chk("mem_fetch_zero", {O_mem_wen, O_mem_wmask, O_mem_wdata}, '0);
            end
         end
         if (prev_mrv && !prev_mrdy) begin
            chk("hold_valid", O_mem_req_valid, 1);
            chk("hold_addr", O_mem_addr, prev_addr);
            chk("hold_wdata", O_mem_wdata, prev_wdata);
            chk("hold_wen_mask", {O_mem_wen, O_mem_wmask}, {prev_wen, prev_wmask});
         end
         if (own_act && !own_ls && I_if_flush) own_drop = 1;
         e_ifrdy = own_act && !own_acc && !own_ls && I_mem_req_ready;
         e_lsrdy = own_act && !own_acc && own_ls && I_mem_req_ready;
         e_ifrv  = own_act && own_acc && !own_ls && I_mem_resp_valid && !own_drop;
         e_lsrv  = own_act && own_acc && own_ls && I_mem_resp_valid;
         chk("if_req_ready", O_if_req_ready, e_ifrdy);
         chk("ls_req_ready", O_ls_req_ready, e_lsrdy);
         chk("if_resp_valid", O_if_resp_valid, e_ifrv);
         chk("ls_resp_valid", O_ls_resp_valid, e_lsrv);
         chk("if_rdata", O_if_rdata, e_ifrv ? own_data : '0);
         if (!(e_lsrv && own_wen)) chk("ls_rdata", O_ls_rdata, e_lsrv ? own_data : '0);
         chk("resp_onehot", O_if_resp_valid && O_ls_resp_valid, 0);
         if (O_if_resp_valid) begin
            n_if_resp++;
            last_if_data = O_if_rdata;
         end
         if (O_ls_resp_valid) n_ls_resp++;
         if (m_pend) begin
            if (I_mem_resp_valid) m_pend = 0;
            else m_cnt--;
         end
         if (I_mem_resp_valid) begin
            own_act  = 0;
            resp_cyc = cyc;
         end
         if (O_mem_req_valid && I_mem_req_ready) begin
            acc_cyc = cyc;
            if (own_act && own_ls && ls_q.size() > 0) begin
               head    = ls_q[0];
               own_wen = head.wen;
               if (head.wen) ref_arr[head.addr] = merge(rd_ref(head.addr), head.wdata, head.wmask);
               own_data = rd_ref(head.addr);
            end else if (own_act && if_q.size() > 0) begin
               own_wen  = 0;
               own_data = rd_ref(if_q[0]);
            end
            own_acc = 1;
            if (O_mem_wen) mem_arr[O_mem_addr] = merge(rd_mem(O_mem_addr), O_mem_wdata, O_mem_wmask);
            m_data = rd_mem(O_mem_addr);
            m_pend = 1;
            m_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
         end
         if (I_if_req_valid && O_if_req_ready) void'(if_q.pop_front());
         if (I_ls_req_valid && O_ls_req_ready) void'(ls_q.pop_front());
         prev_ifv   = I_if_req_valid;
         prev_lsv   = I_ls_req_valid;
         prev_mrv   = O_mem_req_valid;
         prev_mrdy  = I_mem_req_ready;
         prev_addr  = O_mem_addr;
         prev_wdata = O_mem_wdata;
         prev_wmask = O_mem_wmask;
         prev_wen   = O_mem_wen;
      end
      @(posedge I_sys_clk);
      #1;
      cyc++;
   endtask

   task automatic run_drain(input int max_cyc);
      int n;
      n = 0;
      while ((if_q.size() > 0 || ls_q.size() > 0 || own_act || m_pend) && n < max_cyc) begin
         tick();
         n++;
      end
      chk("drain_timeout", if_q.size() > 0 || ls_q.size() > 0 || own_act || m_pend, 0);
      tick();
      tick();
   endtask

   task automatic run_phase(input int max_cyc);
      begin_phase();
      run_drain(max_cyc);
   endtask

   function automatic ls_req_t mk_ls(input logic wen, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic [MW-1:0] m);
      ls_req_t r;
      r.wen = wen; r.addr = a; r.wdata = d; r.wmask = m;
      return r;
   endfunction

   initial begin
      flush_cyc = -1; rst_cyc = -1; rst_force = 1; rdy_mode = 1;
      lat_min = 1; lat_max = 1; flush_pct = 0;
      m_pend = 0; m_cnt = 0; m_data = '0; streak = 0;
      own_act = 0; own_ls = 0; own_acc = 0; own_drop = 0; own_wen = 0; own_data = '0;
      prev_ifv = 0; prev_lsv = 0; prev_mrv = 0; prev_mrdy = 0; prev_wen = 0;
      prev_addr = '0; prev_wdata = '0; prev_wmask = '0;
      begin_phase();

      // Reset, then idle with nothing pending: everything quiet.
      tick();
      tick();
      rst_force = 0;
      tick();
      chk("idle_ctl", {O_if_req_ready, O_if_resp_valid, O_ls_req_ready, O_ls_resp_valid,
                       O_mem_req_valid, O_mem_wen}, '0);
      chk("idle_bus", O_mem_addr | O_mem_wdata | O_if_rdata | O_ls_rdata, '0);

      // Lone fetch: accept in cycle 1, response in cycle 2.
      mem_arr[32'h3000_0000] = 64'h13;
      ref_arr[32'h3000_0000] = 64'h13;
      if_q.push_back(32'h3000_0000);
      run_phase(50);
      chk("lone_order", glog == "I", 1);
      chk("lone_acc_cyc", acc_cyc, 1);
      chk("lone_resp_cyc", resp_cyc, 2);
      chk("lone_if_resp", n_if_resp, 1);
      chk("lone_ls_resp", n_ls_resp, 0);
      chk("lone_data", last_if_data, 64'h13);

      // Simultaneous requests: LSU first, then fetch.
      lat_min = 1; lat_max = 3;
      if_q.push_back(32'h3000_0008);
      ls_q.push_back(mk_ls(1'b0, 32'h8000_0010, '0, '0));
      run_phase(50);
      chk("simul_order", glog == "LI", 1);

      // Starvation bound: six stores against a waiting fetch.
      if_q.push_back(32'h3000_0010);
      for (int k = 0; k < 6; k++)
         ls_q.push_back(mk_ls(1'b1, 32'h8000_0100 + 32'(8 * k), {$urandom, $urandom},
                              MW'($urandom_range(255))));
      run_phase(200);
      chk("starve_order", glog == "LLLLILL", 1);
      for (int k = 0; k < 6; k++) ls_q.push_back(mk_ls(1'b0, 32'h8000_0100 + 32'(8 * k), '0, '0));
      run_phase(200);
      chk("readback_cnt", n_ls_resp, 6);

      // Flush in IF_WAIT drops the response; the next fetch is delivered.
      mem_arr[32'h3000_0040] = 64'hDEAD_BEEF;
      ref_arr[32'h3000_0040] = 64'hDEAD_BEEF;
      lat_min = 3; lat_max = 3;
      if_q.push_back(32'h3000_0040);
      begin_phase();
      flush_cyc = 2;
      run_drain(50);
      flush_cyc = -1;
      chk("flush_no_resp", n_if_resp, 0);
      if_q.push_back(32'h3000_0048);
      run_phase(50);
      chk("post_flush_resp", n_if_resp, 1);
      chk("post_flush_data", last_if_data, dflt(32'h3000_0048));

      // Backpressure: memory not ready for five request cycles.
      lat_min = 1; lat_max = 2;
      rdy_mode = 0;
      ls_q.push_back(mk_ls(1'b1, 32'h8000_0200, 64'h0123_4567_89ab_cdef, 8'h3c));
      begin_phase();
      for (int k = 0; k < 6; k++) tick();
      chk("bp_not_taken", ls_q.size(), 1);
      chk("bp_req_cycles", n_mrv, 5);
      rdy_mode = 1;
      run_drain(50);
      chk("bp_done_resp", n_ls_resp, 1);

      // Reset while a load is waiting for its response.
      lat_min = 3; lat_max = 3;
      ls_q.push_back(mk_ls(1'b0, 32'h8000_0300, '0, '0));
      begin_phase();
      rst_cyc = 2;
      run_drain(50);
      rst_cyc = -1;
      chk("rst_no_ls_resp", n_ls_resp, 0);
      if_q.push_back(32'h3000_0080);
      run_phase(50);
      chk("rst_then_fetch", n_if_resp, 1);
      chk("rst_fetch_data", last_if_data, dflt(32'h3000_0080));

      // Randomised traffic, random ready/latency/flush.
      rdy_mode = 2; lat_min = 1; lat_max = 4; flush_pct = 10;
      begin_phase();
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(3) == 0 && if_q.size() < 2)
            if_q.push_back(32'h3000_0000 + 32'(8 * $urandom_range(15)));
         if ($urandom_range(2) == 0 && ls_q.size() < 3)
            ls_q.push_back(mk_ls(1'($urandom_range(1)), 32'h8000_0000 + 32'(8 * $urandom_range(7)),
                                 {$urandom, $urandom}, MW'($urandom_range(255))));
         tick();
      end
      run_drain(1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
